mdu: RTL
========

# mdu

Multiply/divide unit for the five-stage MIPS pipeline, instantiated inside the execute stage. It owns the HI/LO registers and runs `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` with fixed multi-cycle latency. The execute stage drives `start`/`op`. The hazard unit uses `start`/`busy` to stall any HI/LO-dependent instruction in decode until the result commits.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: qualifies `op`, `a` and `b` for one cycle.
- `op` input 3: operation code.
  - 001 `mult`
  - 010 `multu`
  - 011 `div`
  - 100 `divu`
  - 101 `mthi`
  - 110 `mtlo`
  - 000, 111: no-op.
- `a` input 32: rs operand (dividend / multiplicand / mthi/mtlo data).
- `b` input 32: rt operand (divisor / multiplier).
- `busy` output 1: high while a multiply or divide is in flight.
- `hi` output 32: HI register, registered.
- `lo` output 32: LO register, registered.

## Operation
- **States.**
  - IDLE: `busy`=0; accepts `start`.
  - RUN: `busy`=1; counter counts down.
- **Start of a mult/div (IDLE).** `start`=1 with a mult/div op in IDLE:
  - latch `op`, `a`, `b`;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- **RUN.**
  - Each edge decrements the counter.
  - On the edge where the counter reaches 1: write HI/LO, go to IDLE.
- **Results.**
  - `mult`: {HI,LO} = signed(a) × signed(b), 64-bit.
  - `multu`: {HI,LO} = unsigned 64-bit product.
  - `div`: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `divu`: unsigned quotient and remainder.
- **Divide by zero** (`b`=0, either div op): runs the full `DIV_CYCLES` and leaves HI/LO unchanged.
- **Signed overflow** (`div` of 0x80000000 by 0xFFFFFFFF): LO=0x80000000, HI=0.
- **`mthi`/`mtlo`.**
  - `start`=1 in IDLE writes `a` into HI or LO at that edge.
  - `busy` is never asserted; HI/LO update in one cycle.
- **No-op codes:** `start` with op 000/111 causes no state change.
- **`start` during RUN:** ignored completely (op, operands, HI/LO unaffected). The hazard unit guarantees this never happens; the unit must still be robust to it.
- **Implementation freedom:** arithmetic may be computed at latch time and held, or iteratively. Only the externally visible HI/LO commit timing is specified.
- **Reset** (`reset`=0, any time, including mid-operation):
  - `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0;
  - any in-flight operation is discarded.

## Timing
- **Mult/div sequence.** With `start` high with a mult/div op in cycle 0:
  - the operands are latched at the end-of-cycle-0 edge;
  - `busy`=1 in cycles 1..N (N = `MULT_CYCLES` or `DIV_CYCLES`);
  - HI/LO take their new values at the end-of-cycle-N edge;
  - in cycle N+1, `busy`=0 and `hi`/`lo` are valid.
- **Back-to-back.** A new `start` is accepted in cycle N+1. There are no idle gap cycles between operations.
- **`mthi`/`mtlo`.** `start` in cycle 0 → new value visible on `hi`/`lo` in cycle 1.
- **Stall window for the hazard unit.** An mfhi/mflo/mult/div/mthi/mtlo in decode stalls while (`start` && op is mult/div) || `busy`. The unit itself generates no stall.
- **Outputs.** `busy`, `hi` and `lo` come straight from flops, with no combinational path from inputs.
- **Asynchronous reset.** Reset assertion takes effect immediately, without a clock edge. Deassertion is synchronous to the design's reset release.

## Test plan
- **Reset:** assert `reset`=0 → `hi`=`lo`=0, `busy`=0. Release, then idle 3 cycles → unchanged.
- **`mult`:** a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles. Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **`multu` back-to-back with `divu`:**
  - `multu` a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA.
  - `divu` started in cycle 6 with a=100, b=7 → `busy` cycles 7–16, then hi=2, lo=14.
- **`div` signed and corner cases:**
  - a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - b=0 → `busy` 10 cycles, hi/lo unchanged.
- **`mthi`/`mtlo` and ignored start:**
  - `mthi` a=0x12345678 → hi updates the next cycle, `busy` stays 0.
  - `start` with `mtlo` issued during a running `mult` → ignored; lo gets only the mult result.
- **Mid-operation reset:** assert `reset`=0 during cycle 4 of a `div` → `busy` drops immediately, hi=lo=0. After release, a new `mult` runs normally.

Source files
------------

// File: rtl/mdu.sv
// HI/LO multiply/divide unit with fixed-latency mult/div and one-cycle mthi/mtlo.
// Results are computed when the operands are latched, then held until the commit edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_res_hi, r_res_lo;
  logic          r_wr;

  logic          w_is_mul, w_is_div, w_sdiv, w_smul;
  logic [63:0]   w_a_ext, w_b_ext, w_prod;
  logic [31:0]   w_a_mag, w_b_mag, w_b_safe, w_uq, w_ur, w_q, w_r;
  logic          w_neg_q, w_neg_r;

  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign w_smul   = (i_op == OP_MULT);
  assign w_sdiv   = (i_op == OP_DIV);

  assign w_a_ext = {{32{w_smul & i_a[31]}}, i_a};
  assign w_b_ext = {{32{w_smul & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_mag  = (w_sdiv && i_a[31]) ? -i_a : i_a;
  assign w_b_mag  = (w_sdiv && i_b[31]) ? -i_b : i_b;
  assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_uq     = w_a_mag / w_b_safe;
  assign w_ur     = w_a_mag % w_b_safe;
  assign w_neg_q  = w_sdiv && (i_a[31] ^ i_b[31]);
  assign w_neg_r  = w_sdiv && i_a[31];
  assign w_q      = w_neg_q ? -w_uq : w_uq;
  assign w_r      = w_neg_r ? -w_ur : w_ur;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_wr     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_start && (w_is_mul || w_is_div)) begin
        r_state  <= S_RUN;
        r_cnt    <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        r_res_hi <= w_is_mul ? w_prod[63:32] : w_r;
        r_res_lo <= w_is_mul ? w_prod[31:0]  : w_q;
        r_wr     <= w_is_mul || (i_b != 32'd0);
      end else if (i_start && (i_op == OP_MTHI)) begin
        r_hi <= i_a;
      end else if (i_start && (i_op == OP_MTLO)) begin
        r_lo <= i_a;
      end
    end else begin
      if (r_cnt == CW'(1)) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        if (r_wr) begin
          r_hi <= r_res_hi;
          r_lo <= r_res_lo;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
